// File: rtl/muldiv_if.sv
// Request/response bundle between a requester and the iterative multiply/divide unit.
// Signal names follow the RV32M execution-stage naming used by the core.
interface muldiv_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT_LENGTH = 3
);
    logic                    start;
    logic [FUNCT_LENGTH-1:0] Funct;
    logic [DATA_WIDTH-1:0]   SrcA;
    logic [DATA_WIDTH-1:0]   SrcB;
    logic                    busy;
    logic                    done;
    logic [DATA_WIDTH-1:0]   MDResult;

    modport master (
        output start, Funct, SrcA, SrcB,
        input  busy, done, MDResult
    );

    modport slave (
        input  start, Funct, SrcA, SrcB,
        output busy, done, MDResult
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up and a fast path for div-by-zero/overflow.
module muldiv_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT_LENGTH = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  mdu
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST  = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_1 = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0]  ZERO = {W{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_iter;
    logic            w_finish;

    logic            r_busy;
    logic            r_done;
    logic [W-1:0]    r_md_result;

    logic [2:0]      r_op;
    logic            r_res_neg;
    logic            r_rem_neg;
    logic            r_special;
    logic [W-1:0]    r_special_res;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
    logic [W-1:0]    r_opb;
    logic [CW-1:0]   r_cnt;

    logic [2:0]      w_op;
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [W-1:0]    w_mag_a;
    logic [W-1:0]    w_mag_b;
    logic            w_div0;
    logic            w_ovf;
    logic [W-1:0]    w_special_res;

    logic [W:0]      w_add;
    logic [W:0]      w_shift;
    logic [W:0]      w_diff;
    logic            w_ge;
    logic [2*W-1:0]  w_prod;
    logic [2*W-1:0]  w_prod_s;
    logic [W-1:0]    w_quo;
    logic [W-1:0]    w_rem;
    logic [W-1:0]    w_final;

    assign w_op       = mdu.Funct[2:0];
    assign w_is_div   = w_op[2];
    assign w_a_signed = (w_op == 3'b001) || (w_op == 3'b010) || (w_op == 3'b100) || (w_op == 3'b110);
    assign w_b_signed = (w_op == 3'b001) || (w_op == 3'b100) || (w_op == 3'b110);
    assign w_a_neg    = w_a_signed & mdu.SrcA[W-1];
    assign w_b_neg    = w_b_signed & mdu.SrcB[W-1];
    assign w_mag_a    = w_a_neg ? -mdu.SrcA : mdu.SrcA;
    assign w_mag_b    = w_b_neg ? -mdu.SrcB : mdu.SrcB;
    assign w_div0     = w_is_div & (mdu.SrcB == ZERO);
    assign w_ovf      = w_is_div & ~w_op[0] & (mdu.SrcA == MIN_NEG) & (mdu.SrcB == ALL_ONES);

    // Fixed results for operations that bypass the iteration.
    always_comb begin
        w_special_res = ZERO;
        if (w_div0) begin
            w_special_res = w_op[1] ? mdu.SrcA : ALL_ONES;
        end else if (w_ovf) begin
            w_special_res = w_op[1] ? ZERO : mdu.SrcA;
        end else begin
            w_special_res = ZERO;
        end
    end

    // Since the partial remainder stays below the divisor, bit W of the
    // (W+1)-bit trial difference is exactly the borrow.
    assign w_add   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opb : ZERO)};
    assign w_shift = {r_hi, r_lo[W-1]};
    assign w_diff  = w_shift - {1'b0, r_opb};
    assign w_ge    = ~w_diff[W];

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_res_neg ? -w_prod : w_prod;
    assign w_quo    = r_res_neg ? -r_lo : r_lo;
    assign w_rem    = r_rem_neg ? -r_hi : r_hi;

    // Select and sign-correct the completed result.
    always_comb begin
        w_final = ZERO;
        if (r_special) begin
            w_final = r_special_res;
        end else begin
            case (r_op)
                3'b000:                 w_final = w_prod_s[W-1:0];
                3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*W-1:W];
                3'b100, 3'b101:         w_final = w_quo;
                3'b110, 3'b111:         w_final = w_rem;
                default:                w_final = ZERO;
            endcase
        end
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == CALC);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_iter      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (mdu.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                if (r_cnt == LAST) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_iter      = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture and one radix-2 step per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op          <= 3'b000;
            r_res_neg     <= 1'b0;
            r_rem_neg     <= 1'b0;
            r_special     <= 1'b0;
            r_special_res <= ZERO;
            r_hi          <= ZERO;
            r_lo          <= ZERO;
            r_opb         <= ZERO;
            r_cnt         <= {CW{1'b0}};
        end else if (w_accept) begin
            r_op          <= w_op;
            r_res_neg     <= w_a_neg ^ w_b_neg;
            r_rem_neg     <= w_a_neg;
            r_special     <= w_div0 | w_ovf;
            r_special_res <= w_special_res;
            r_hi          <= ZERO;
            r_lo          <= w_mag_a;
            r_opb         <= w_mag_b;
            r_cnt         <= {CW{1'b0}};
        end else if (w_iter) begin
            if (r_special) begin
                r_cnt <= LAST;
            end else begin
                r_cnt <= r_cnt + CNT_1;
                if (r_op[2]) begin
                    r_hi <= w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
                    r_lo <= {r_lo[W-2:0], w_ge};
                end else begin
                    r_hi <= w_add[W:1];
                    r_lo <= {w_add[0], r_lo[W-1:1]};
                end
            end
        end
    end

    // Result register only changes when an operation completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_result <= ZERO;
        end else if (w_finish) begin
            r_md_result <= w_final;
        end
    end

    assign mdu.busy     = r_busy;
    assign mdu.done     = r_done;
    assign mdu.MDResult = r_md_result;
endmodule
